// File: rtl/demux_1_to_2_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_to_2_stream
// Description : Registered 1-to-2 valid/ready stream demultiplexer with a
//               one-entry holding slot per output channel. Optional
//               per-channel delivery counters are enabled by DEMUX_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_to_2_stream #(
    parameter int DATA_W = 8
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
`endif
);

    localparam logic [0:0] c_empty = 1'b0;
    localparam logic [0:0] c_full  = 1'b1;

    logic [1:0]        w_out_ready;
    logic [1:0]        w_state;
    logic [DATA_W-1:0] w_data [2];
    logic              w_in_ready;
    logic              w_accept;
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0]  w_cnt [2];
`endif

    assign w_out_ready = {out1_ready, out0_ready};

    // A slot draining this cycle can take a new word, so the selected
    // channel's ready passes straight through to the input.
    assign w_in_ready = (w_state[in_sel] == c_empty) | w_out_ready[in_sel];
    assign w_accept   = in_valid & w_in_ready;
    assign in_ready   = w_in_ready;

    for (genvar k = 0; k < 2; k++) begin : g_slot
        logic [0:0]        r_state;
        logic [DATA_W-1:0] r_data;
        logic              w_load;
        logic              w_drain;

        assign w_load  = w_accept & (in_sel == 1'(k));
        assign w_drain = (r_state == c_full) & w_out_ready[k];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= c_empty;
                r_data  <= '0;
            end else if (w_load) begin
                r_state <= c_full;
                r_data  <= in_data;
            end else if (w_drain) begin
                r_state <= c_empty;
            end
        end

        assign w_state[k] = r_state;
        assign w_data[k]  = r_data;

`ifdef DEMUX_CNT_EN
        logic [CNT_W-1:0] r_cnt;

        // Wraps naturally modulo 2**CNT_W.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_drain) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_cnt[k] = r_cnt;
`endif
    end

    assign out0_valid = (w_state[0] == c_full);
    assign out1_valid = (w_state[1] == c_full);
    assign out0_data  = w_data[0];
    assign out1_data  = w_data[1];

`ifdef DEMUX_CNT_EN
    assign cnt0 = w_cnt[0];
    assign cnt1 = w_cnt[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_1_to_2_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1_to_2_stream
// Description : Self-checking bench for demux_1_to_2_stream using a per-channel
//               queue model plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_to_2_stream;

    localparam int DATA_W = 8;
`ifdef DEMUX_CNT_EN
    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_sel = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out0_ready = 1'b0;
    logic              out1_ready = 1'b0;
    logic              in_ready;
    logic              out0_valid;
    logic              out1_valid;
    logic [DATA_W-1:0] out0_data;
    logic [DATA_W-1:0] out1_data;
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    demux_1_to_2_stream #(
        .DATA_W(DATA_W)
`ifdef DEMUX_CNT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out0_data (out0_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out1_data (out1_data)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: each channel is a queue of words handed over but not
    // yet consumed; a channel may take a word when empty or being consumed.
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] m_last0 = '0;
    logic [DATA_W-1:0] m_last1 = '0;
    int                m_cnt0 = 0;
    int                m_cnt1 = 0;
    bit                chk_en = 1'b0;

    function automatic bit model_ready(input logic sel);
        if (sel) return (q1.size() == 0) || out1_ready;
        return (q0.size() == 0) || out0_ready;
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_last0 = '0;
            m_last1 = '0;
            m_cnt0  = 0;
            m_cnt1  = 0;
            chk_en  = 1'b1;
        end else begin
            acc = in_valid && model_ready(in_sel);
            if (q0.size() > 0 && out0_ready) begin
                void'(q0.pop_front());
                m_cnt0++;
            end
            if (q1.size() > 0 && out1_ready) begin
                void'(q1.pop_front());
                m_cnt1++;
            end
            if (acc) begin
                if (in_sel) begin
                    q1.push_back(in_data);
                    m_last1 = in_data;
                end else begin
                    q0.push_back(in_data);
                    m_last0 = in_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
            check("model_out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
            check("model_out0_data", 32'(out0_data), 32'(q0.size() > 0 ? q0[0] : m_last0));
            check("model_out1_data", 32'(out1_data), 32'(q1.size() > 0 ? q1[0] : m_last1));
            if (in_valid && !rst) check("model_in_ready", 32'(in_ready), 32'(model_ready(in_sel)));
`ifdef DEMUX_CNT_EN
            check("model_cnt0", 32'(cnt0), 32'(m_cnt0 % CNT_MOD));
            check("model_cnt1", 32'(cnt1), 32'(m_cnt1 % CNT_MOD));
`endif
        end
    end

    // Holds the word until a negedge sample shows in_ready, then returns #1
    // after the accepting edge with in_valid still asserted.
    task automatic send(input logic [DATA_W-1:0] d, input logic s, output int stalls);
        bit got;
        stalls   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        forever begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) break;
            stalls++;
            if (stalls > 50) begin
                check("send_timeout", 32'(stalls), 32'd0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        int total;

        // Reset held with a word offered on the input
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out0_valid", 32'(out0_valid), 32'd0);
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out0_data", 32'(out0_data), 32'd0);
        check("rst_out1_data", 32'(out1_data), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        idle(1);

        // Routing
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(8'hA5, 1'b0, st);
        check("route_out0_valid", 32'(out0_valid), 32'd1);
        check("route_out0_data", 32'(out0_data), 32'hA5);
        send(8'h3C, 1'b1, st);
        check("route_out1_data", 32'(out1_data), 32'h3C);
        idle(1);
`ifdef DEMUX_CNT_EN
        check("route_cnt0", 32'(cnt0), 32'd1);
        check("route_cnt1", 32'(cnt1), 32'd1);
`endif
        idle(1);

        // Isolation: channel 0 stalled behind word 11
        out0_ready = 1'b0;
        send(8'h11, 1'b0, st);
        in_data = 8'h22;
        repeat (3) begin
            @(negedge clk);
            check("iso_in_ready", 32'(in_ready), 32'd0);
            check("iso_out0_data", 32'(out0_data), 32'h11);
        end
        @(posedge clk);
        #1;
        out0_ready = 1'b1;
        send(8'h22, 1'b0, st);
        check("iso_follow_data", 32'(out0_data), 32'h22);
        send(8'h33, 1'b1, st);
        check("iso_ch1_data", 32'(out1_data), 32'h33);
        idle(2);

        // Back-to-back stream on channel 1
        total = 0;
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b1, st);
            total += st;
        end
        check("b2b_last_data", 32'(out1_data), 32'h0F);
        idle(2);
        check("b2b_stalls", 32'(total), 32'd0);

        // Simultaneous drain and accept on channel 0
        out0_ready = 1'b0;
        send(8'h55, 1'b0, st);
        check("dra_hold_data", 32'(out0_data), 32'h55);
        out0_ready = 1'b1;
        send(8'h66, 1'b0, st);
        check("dra_stalls", 32'(st), 32'd0);
        check("dra_out0_valid", 32'(out0_valid), 32'd1);
        check("dra_out0_data", 32'(out0_data), 32'h66);
        idle(2);

        // 17 words on channel 0 (22 total -> 6 with a 4-bit counter)
        for (int i = 0; i < 17; i++) send(8'h80 + 8'(i), 1'b0, st);
        idle(2);
`ifdef DEMUX_CNT_EN
        check("wrap_cnt0", 32'(cnt0), 32'd6);
        check("wrap_cnt1", 32'(cnt1), 32'd2);
`endif

        // Reset while channel 1 holds a word and its consumer is ready
        out1_ready = 1'b0;
        send(8'h77, 1'b1, st);
        in_valid = 1'b0;
        check("mid_pre_valid", 32'(out1_valid), 32'd1);
        rst        = 1'b1;
        out1_ready = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        out1_ready = 1'b0;
        check("mid_out1_valid", 32'(out1_valid), 32'd0);
`ifdef DEMUX_CNT_EN
        check("mid_cnt0", 32'(cnt0), 32'd0);
        check("mid_cnt1", 32'(cnt1), 32'd0);
`endif
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
